// File: rtl/av_mult_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : av_sched_pkg
// Description : Shared types and constants for the AV-multiply scheduler:
//               FSM state encoding, token precision codes, watchdog default.
// Revision    : 1.0 - initial release
// ============================================================================
package av_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } sched_state_t;

    // Token precision codes carried on prec_in / mul_precision
    localparam logic [3:0] PREC_INT4 = 4'd0;
    localparam logic [3:0] PREC_INT8 = 4'd1;
    localparam logic [3:0] PREC_FP16 = 4'd2;

    // Default watchdog limit in cycles for datapath completion
    localparam int TIMEOUT_DEFAULT = 256;

endpackage
`default_nettype wire

// File: rtl/av_mult_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : av_mult_scheduler_if
// Description : Requester and datapath signals of the AV-multiply scheduler.
//               slave = scheduler side, master = requesters/datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface av_mult_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int L       = 8
);
    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     req;
    logic [4*L*NUM_REQ-1:0] prec_in;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     req_done;
    logic [NUM_REQ-1:0]     req_err;
    logic                   mul_start;
    logic                   mul_done;
    logic [SEL_W-1:0]       mul_sel;
    logic [4*L-1:0]         mul_precision;
    logic                   busy;
    logic                   err_sticky;

    modport slave (
        input  req, prec_in, mul_done,
        output gnt, req_done, req_err, mul_start, mul_sel, mul_precision,
               busy, err_sticky
    );

    modport master (
        output req, prec_in, mul_done,
        input  gnt, req_done, req_err, mul_start, mul_sel, mul_precision,
               busy, err_sticky
    );

endinterface
`default_nettype wire

// File: rtl/av_mult_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               above ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

    logic [SEL_W-1:0] idx;

    assign any_req = |req;

    // Scan offsets from farthest to nearest so the nearest asserted one wins
    always_comb begin
        winner = ptr;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = SEL_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/av_mult_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : av_mult_scheduler
// Description : Round-robin scheduler sharing one AV-multiply datapath among
//               NUM_REQ requesters, with a completion watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module av_mult_scheduler
    import av_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int L           = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    av_mult_scheduler_if.slave bus
);

    localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REQ - 1);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic [WD_W-1:0]    wd_cnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [4*L-1:0]     prec_q;
    logic               timed_out;
    logic               err_sticky_q;
    logic               start_pulse;
    logic               busy_w;
    logic [NUM_REQ-1:0] done_vec;
    logic [NUM_REQ-1:0] err_vec;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state outputs; mul_done only matters in S_WAIT
    always_comb begin
        state_next  = state;
        start_pulse = 1'b0;
        busy_w      = 1'b1;
        done_vec    = '0;
        err_vec     = '0;
        case (state)
            S_IDLE: begin
                busy_w = 1'b0;
                if (any_req) state_next = S_GRANT;
            end
            S_GRANT: state_next = S_START;
            S_START: begin
                start_pulse = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_done || (wd_cnt == WD_LAST)) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                state_next = S_IDLE;
                if (timed_out) err_vec  = gnt_q;
                else           done_vec = gnt_q;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Grant capture, watchdog, outcome flag and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            wd_cnt       <= '0;
            gnt_q        <= '0;
            sel_q        <= '0;
            prec_q       <= '0;
            timed_out    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                gnt_q  <= NUM_REQ'(1) << winner;
                sel_q  <= winner;
                prec_q <= bus.prec_in[int'(winner)*4*L +: 4*L];
            end
            if (state == S_START) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            // Last value before leaving S_WAIT records the outcome; done wins
            if (state == S_WAIT) begin
                timed_out <= !bus.mul_done;
                if (!bus.mul_done && (wd_cnt == WD_LAST)) err_sticky_q <= 1'b1;
            end
            if (state == S_RELEASE) begin
                gnt_q <= '0;
                ptr   <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            end
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.mul_sel       = sel_q;
    assign bus.mul_precision = prec_q;
    assign bus.mul_start     = start_pulse;
    assign bus.busy          = busy_w;
    assign bus.req_done      = done_vec;
    assign bus.req_err       = err_vec;
    assign bus.err_sticky    = err_sticky_q;

endmodule
`default_nettype wire

// File: doc/av_mult_scheduler.md
AV_MULT_SCHEDULER -- requirements
Module: av_mult_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one AV-multiply datapath.
REQ-002 SHALL have parameter L, default 8, tokens per job (precision codes per requester).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, watchdog limit in cycles for datapath completion.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester job request, level.
REQ-007 SHALL have port prec_in, input, 4*L*NUM_REQ, per-requester token precision codes; requester r, token t at bits [(r*L+t)*4 +: 4].
REQ-008 SHALL have port gnt, output, NUM_REQ, one-hot grant, held for the whole job.
REQ-009 SHALL have port req_done, output, NUM_REQ, one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port req_err, output, NUM_REQ, one-cycle timeout-abort pulse to the granted requester.
REQ-011 SHALL have port mul_start, output, 1, one-cycle start pulse to the datapath.
REQ-012 SHALL have port mul_done, input, 1, datapath completion.
REQ-013 SHALL have port mul_sel, output, $clog2(NUM_REQ), index of granted requester (operand mux select).
REQ-014 SHALL have port mul_precision, output, 4*L, registered precision codes of granted requester.
REQ-015 SHALL have port busy, output, 1, high in every state except S_IDLE.
REQ-016 SHALL have port err_sticky, output, 1, set on any timeout; cleared only by reset.

Function
REQ-017 SHALL implement states S_IDLE, S_GRANT, S_START, S_WAIT, S_RELEASE.
REQ-018 SHALL move S_IDLE->S_GRANT on the edge where any req bit is high; winner chosen round-robin from pointer ptr.
REQ-019 SHALL select winner as the first asserted req index at or above ptr, wrapping modulo NUM_REQ.
REQ-020 SHALL, on entering S_GRANT, register gnt (one-hot winner), mul_sel=winner, mul_precision=prec_in slice of winner; these SHALL hold unchanged until exit of S_RELEASE.
REQ-021 SHALL move S_GRANT->S_START unconditionally; mul_start SHALL be high exactly during S_START (one cycle).
REQ-022 SHALL move S_START->S_WAIT unconditionally; mul_done during S_GRANT/S_START/S_IDLE/S_RELEASE SHALL be ignored.
REQ-023 SHALL count cycles in S_WAIT with a watchdog counter cleared on entry to S_WAIT.
REQ-024 SHALL move S_WAIT->S_RELEASE when mul_done=1, pulsing req_done[winner] during S_RELEASE.
REQ-025 SHALL move S_WAIT->S_RELEASE when watchdog reaches TIMEOUT_CYC-1 without mul_done, pulsing req_err[winner] and setting err_sticky.
REQ-026 SHALL treat mul_done in the timeout cycle as success (done wins; no req_err, err_sticky unchanged).
REQ-027 SHALL move S_RELEASE->S_IDLE, clearing gnt and setting ptr=(winner+1) mod NUM_REQ.
REQ-028 SHALL ignore req deassertion after grant; the job runs to completion.
REQ-029 SHALL never assert req_done and req_err in the same cycle, and at most one bit of each.
REQ-030 SHALL spend at least one S_IDLE cycle between jobs; back-to-back requesters are granted on the next S_IDLE edge.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, force state=S_IDLE, ptr=0, watchdog=0, gnt=0, req_done=0, req_err=0, mul_start=0, mul_sel=0, mul_precision=0, busy=0, err_sticky=0.
REQ-032 SHALL abort any in-flight job on reset without issuing req_done or req_err.

Structure
REQ-033 SHALL place the state enum, precision code constants (PREC_INT4=0, PREC_INT8=1, PREC_FP16=2) and TIMEOUT default in package av_sched_pkg.
REQ-034 SHALL implement winner selection in one combinational sub-module rr_arbiter (inputs req, ptr; outputs winner index, any_req).

Verification
REQ-035 SHALL test: req=4'b0001, mul_done 10 cycles after mul_start -> gnt=0001, mul_start one cycle two edges after req, req_done[0] one cycle after mul_done, busy low after.
REQ-036 SHALL test: req=4'b1111 held, each job completing -> grant order 0,1,2,3,0, ptr wrapping.
REQ-037 SHALL test: TIMEOUT_CYC=16, mul_done never -> req_err[sel] pulse after 16 S_WAIT cycles, err_sticky=1, next job still runs.
REQ-038 SHALL test: mul_done exactly in watchdog cycle 15 -> req_done, no req_err, err_sticky=0.
REQ-039 SHALL test: rst_n=0 during S_WAIT -> all outputs zero next edge, no done/err pulse; req=4'b0100 afterwards -> gnt=0100 (ptr=0 start).
REQ-040 SHALL test: prec_in for requester 2 = all 4'd1, others 4'd0 -> mul_precision all 4'd1 while gnt=0100, stable even if prec_in changes mid-job.
